// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants: opcodes/functs (also used by the control decoder), loader mnemonic ids,
// loader FSM states and small word-packing helpers.
package cpu_isa_pkg;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;

    typedef enum logic [3:0] {
        MnAdd  = 4'd0,
        MnSub  = 4'd1,
        MnAnd  = 4'd2,
        MnOr   = 4'd3,
        MnAddi = 4'd4,
        MnAndi = 4'd5,
        MnOri  = 4'd6,
        MnLw   = 4'd7,
        MnSw   = 4'd8,
        MnBeq  = 4'd9,
        MnBne  = 4'd10,
        MnJ    = 4'd11
    } mnemonic_e;

    typedef enum logic [1:0] {
        StIdle,
        StAccept,
        StWrite,
        StDone
    } load_state_e;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {OpRtype, rs, rt, rd, 5'b00000, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: mnemonic id plus fields -> 32-bit instruction word and a legality flag.
// Fields a format does not use never reach the word.
module instr_encode
    import cpu_isa_pkg::*;
(
    input  logic [3:0]  mn_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    input  logic [25:0] target_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (mn_i)
            MnAdd:   word_o = enc_r(rs_i, rt_i, rd_i, FnAdd);
            MnSub:   word_o = enc_r(rs_i, rt_i, rd_i, FnSub);
            MnAnd:   word_o = enc_r(rs_i, rt_i, rd_i, FnAnd);
            MnOr:    word_o = enc_r(rs_i, rt_i, rd_i, FnOr);
            MnAddi:  word_o = enc_i(OpAddi, rs_i, rt_i, imm_i);
            MnAndi:  word_o = enc_i(OpAndi, rs_i, rt_i, imm_i);
            MnOri:   word_o = enc_i(OpOri, rs_i, rt_i, imm_i);
            MnLw:    word_o = enc_i(OpLw, rs_i, rt_i, imm_i);
            MnSw:    word_o = enc_i(OpSw, rs_i, rt_i, imm_i);
            MnBeq:   word_o = enc_i(OpBeq, rs_i, rt_i, imm_i);
            MnBne:   word_o = enc_i(OpBne, rs_i, rt_i, imm_i);
            MnJ:     word_o = {OpJ, target_i};
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_loader.sv
// Accepts symbolic instructions over valid/ready, encodes them and writes them to consecutive
// IMEM word addresses from BASE, holding the CPU in reset until a clean load completes.
module instr_loader
    import cpu_isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BASE   = 0
) (
    input  logic              Clk,
    input  logic              Clrn,
    input  logic              Start,
    input  logic              In_valid,
    output logic              In_ready,
    input  logic [3:0]        Mn,
    input  logic [4:0]        Rs,
    input  logic [4:0]        Rt,
    input  logic [4:0]        Rd,
    input  logic [15:0]       Imm,
    input  logic [25:0]       Target,
    input  logic              Last,
    output logic              Im_we,
    output logic [ADDR_W-1:0] Im_addr,
    output logic [31:0]       Im_wdata,
    output logic              Cpu_hold,
    output logic              Done,
    output logic              Err,
    output logic [ADDR_W:0]   Count
);

    localparam logic [ADDR_W-1:0] PtrBase = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] PtrMax  = '1;

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;

    logic [31:0]       enc_word;
    logic              enc_legal;

    instr_encode u_encode (
        .mn_i     (Mn),
        .rs_i     (Rs),
        .rt_i     (Rt),
        .rd_i     (Rd),
        .imm_i    (Imm),
        .target_i (Target),
        .word_o   (enc_word),
        .legal_o  (enc_legal)
    );

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= StIdle;
            ptr_q   <= PtrBase;
            count_q <= '0;
            err_q   <= 1'b0;
            word_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            word_q  <= word_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        count_d  = count_q;
        err_d    = err_q;
        word_d   = word_q;
        last_d   = last_q;
        In_ready = 1'b0;
        Im_we    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (Start) begin
                    state_d = StAccept;
                    ptr_d   = PtrBase;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            StAccept: begin
                In_ready = 1'b1;
                if (In_valid) begin
                    word_d = enc_word;
                    last_d = Last;
                    if (enc_legal) begin
                        state_d = StWrite;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StWrite: begin
                Im_we   = 1'b1;
                count_d = count_q + 1'b1;
                // Saturate at the top word so a full IMEM never wraps onto BASE.
                if (ptr_q != PtrMax) begin
                    ptr_d = ptr_q + 1'b1;
                end
                if (last_q) begin
                    state_d = StDone;
                end else if (ptr_q == PtrMax) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    state_d = StAccept;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign Im_addr  = ptr_q;
    assign Im_wdata = word_q;
    assign Count    = count_q;
    assign Err      = err_q;
    assign Done     = (state_q == StDone);
    assign Cpu_hold = !((state_q == StDone) && !err_q);

endmodule

// File: tb/tb_instr_loader.sv
// Randomized self-checking bench for instr_loader: programs are encoded and laid out by a
// behavioural model, and the captured IMEM writes and status outputs are compared against it.
module tb_instr_loader;

    localparam int unsigned AW   = 3;
    localparam int unsigned BASE = 0;
    localparam int unsigned CAP  = 1 << AW;

    typedef struct packed {
        logic [3:0]  mn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] target;
        logic        last;
    } instr_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          Clk, Clrn, Start, In_valid, In_ready, Last;
    logic [3:0]    Mn;
    logic [4:0]    Rs, Rt, Rd;
    logic [15:0]   Imm;
    logic [25:0]   Target;
    logic          Im_we, Cpu_hold, Done, Err;
    logic [AW-1:0] Im_addr;
    logic [31:0]   Im_wdata;
    logic [AW:0]   Count;

    instr_loader #(.ADDR_W(AW), .BASE(BASE)) dut (
        .Clk      (Clk),
        .Clrn     (Clrn),
        .Start    (Start),
        .In_valid (In_valid),
        .In_ready (In_ready),
        .Mn       (Mn),
        .Rs       (Rs),
        .Rt       (Rt),
        .Rd       (Rd),
        .Imm      (Imm),
        .Target   (Target),
        .Last     (Last),
        .Im_we    (Im_we),
        .Im_addr  (Im_addr),
        .Im_wdata (Im_wdata),
        .Cpu_hold (Cpu_hold),
        .Done     (Done),
        .Err      (Err),
        .Count    (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {legal, word} straight from the instruction-format tables.
    function automatic logic [32:0] ref_encode(input instr_t i);
        case (i.mn)
            4'd0:    return {1'b1, 6'b000000, i.rs, i.rt, i.rd, 5'b00000, 6'b100000};
            4'd1:    return {1'b1, 6'b000000, i.rs, i.rt, i.rd, 5'b00000, 6'b100010};
            4'd2:    return {1'b1, 6'b000000, i.rs, i.rt, i.rd, 5'b00000, 6'b100100};
            4'd3:    return {1'b1, 6'b000000, i.rs, i.rt, i.rd, 5'b00000, 6'b100101};
            4'd4:    return {1'b1, 6'b001000, i.rs, i.rt, i.imm};
            4'd5:    return {1'b1, 6'b001100, i.rs, i.rt, i.imm};
            4'd6:    return {1'b1, 6'b001101, i.rs, i.rt, i.imm};
            4'd7:    return {1'b1, 6'b100011, i.rs, i.rt, i.imm};
            4'd8:    return {1'b1, 6'b101011, i.rs, i.rt, i.imm};
            4'd9:    return {1'b1, 6'b000100, i.rs, i.rt, i.imm};
            4'd10:   return {1'b1, 6'b000101, i.rs, i.rt, i.imm};
            4'd11:   return {1'b1, 6'b000010, i.target};
            default: return 33'h0;
        endcase
    endfunction

    function automatic instr_t mk(input int mn, input int rs, input int rt, input int rd,
                                  input int imm, input int target, input bit last);
        instr_t i;
        i.mn     = 4'(mn);
        i.rs     = 5'(rs);
        i.rt     = 5'(rt);
        i.rd     = 5'(rd);
        i.imm    = 16'(imm);
        i.target = 26'(target);
        i.last   = last;
        return i;
    endfunction

    function automatic instr_t rand_instr(input bit last, input bit allow_bad);
        instr_t i;
        if (allow_bad && $urandom_range(0, 99) < 8) i.mn = 4'($urandom_range(12, 15));
        else i.mn = 4'($urandom_range(0, 11));
        i.rs     = 5'($urandom);
        i.rt     = 5'($urandom);
        i.rd     = 5'($urandom);
        i.imm    = 16'($urandom);
        i.target = 26'($urandom);
        i.last   = last;
        return i;
    endfunction

    // Write monitor plus per-cycle handshake/latency checks.
    wr_t  act_q[$];
    wr_t  last_writes[$];
    bit   mon_en = 1'b0;
    bit   hs_prev = 1'b0;
    bit   legal_prev = 1'b0;

    always @(negedge Clk) begin
        instr_t      cur;
        logic [32:0] enc;
        wr_t         w;
        if (mon_en) begin
            check_eq("we_latency", 64'(Im_we), 64'(hs_prev & legal_prev));
            if (hs_prev) check_eq("ready_after_hs", 64'(In_ready), 64'd0);
            if (Done) check_eq("ready_in_done", 64'(In_ready), 64'd0);
            if (Im_we) begin
                w.addr = Im_addr;
                w.data = Im_wdata;
                act_q.push_back(w);
            end
            cur        = mk(int'(Mn), int'(Rs), int'(Rt), int'(Rd), int'(Imm), int'(Target), Last);
            enc        = ref_encode(cur);
            hs_prev    = In_valid & In_ready;
            legal_prev = enc[32];
        end else begin
            hs_prev    = 1'b0;
            legal_prev = 1'b0;
        end
    end

    task automatic drive_instr(input instr_t i);
        Mn       = i.mn;
        Rs       = i.rs;
        Rt       = i.rt;
        Rd       = i.rd;
        Imm      = i.imm;
        Target   = i.target;
        Last     = i.last;
        In_valid = 1'b1;
    endtask

    // Inputs change 1ns after the rising edge; Start is randomly waved while busy.
    task automatic send(input instr_t i, output bit accepted);
        accepted = 1'b0;
        drive_instr(i);
        for (int c = 0; c < 50; c++) begin
            Start = 1'b0;
            if (Done) return;
            if (In_ready) begin
                @(posedge Clk);
                #1;
                accepted = 1'b1;
                return;
            end
            Start = ($urandom_range(0, 3) == 0);
            @(posedge Clk);
            #1;
        end
        Start = 1'b0;
        check_eq("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_session(input instr_t prog[$], input int max_gap);
        wr_t         exp_q[$];
        bit          exp_err;
        int unsigned ptr;
        logic [32:0] enc;
        wr_t         w;
        bit          acc;
        int          gap;

        exp_err = 1'b0;
        ptr     = BASE;
        for (int k = 0; k < prog.size(); k++) begin
            enc = ref_encode(prog[k]);
            if (!enc[32]) begin
                exp_err = 1'b1;
                break;
            end
            w.addr = AW'(ptr);
            w.data = enc[31:0];
            exp_q.push_back(w);
            if (prog[k].last) break;
            if (ptr == CAP - 1) begin
                exp_err = 1'b1;
                break;
            end
            ptr++;
        end

        In_valid = 1'b0;
        Start    = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        check_eq("start_done", 64'(Done), 64'd0);
        check_eq("start_err", 64'(Err), 64'd0);
        check_eq("start_count", 64'(Count), 64'd0);
        check_eq("start_ready", 64'(In_ready), 64'd1);

        for (int k = 0; k < prog.size(); k++) begin
            gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            if (gap > 0) In_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                Start = Done ? 1'b0 : ($urandom_range(0, 3) == 0);
                @(posedge Clk);
                #1;
            end
            Start = 1'b0;
            if (Done) break;
            send(prog[k], acc);
            if (!acc) break;
        end
        In_valid = 1'b0;
        Start    = 1'b0;
        for (int c = 0; c < 10 && !Done; c++) begin
            @(posedge Clk);
            #1;
        end

        check_eq("end_done", 64'(Done), 64'd1);
        check_eq("end_err", 64'(Err), 64'(exp_err));
        check_eq("end_count", 64'(Count), 64'(exp_q.size()));
        check_eq("end_cpu_hold", 64'(Cpu_hold), 64'(exp_err));
        check_eq("n_writes", 64'(act_q.size()), 64'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            check_eq("wr_addr", 64'(act_q[k].addr), 64'(exp_q[k].addr));
            check_eq("wr_data", 64'(act_q[k].data), 64'(exp_q[k].data));
        end
        last_writes = act_q;
        act_q.delete();
    endtask

    initial begin
        instr_t prog[$];
        bit     acc;
        int     len;
        bit     with_last;

        Clrn     = 1'b0;
        Start    = 1'b0;
        In_valid = 1'b0;
        drive_instr(mk(0, 0, 0, 0, 0, 0, 1'b0));
        In_valid = 1'b0;
        #3;
        check_eq("rst_we", 64'(Im_we), 64'd0);
        check_eq("rst_addr", 64'(Im_addr), 64'(BASE));
        check_eq("rst_wdata", 64'(Im_wdata), 64'd0);
        check_eq("rst_hold", 64'(Cpu_hold), 64'd1);
        check_eq("rst_done", 64'(Done), 64'd0);
        check_eq("rst_err", 64'(Err), 64'd0);
        check_eq("rst_count", 64'(Count), 64'd0);
        check_eq("rst_ready", 64'(In_ready), 64'd0);
        #19;
        Clrn = 1'b1;
        @(posedge Clk);
        #1;
        check_eq("idle_ready", 64'(In_ready), 64'd0);
        check_eq("idle_hold", 64'(Cpu_hold), 64'd1);
        mon_en = 1'b1;

        // Single add.
        prog = '{mk(0, 1, 2, 3, 0, 0, 1'b1)};
        run_session(prog, 0);
        check_eq("add_word", 64'(last_writes.size() > 0 ? last_writes[0].data : 32'h0),
                 64'h00221820);

        // Back-to-back lw, sw, beq, j.
        prog = '{mk(7, 0, 1, 0, 4, 0, 1'b0), mk(8, 2, 3, 0, 8, 0, 1'b0),
                 mk(9, 0, 0, 0, 16'hFFFE, 0, 1'b0), mk(11, 0, 0, 0, 0, 3, 1'b1)};
        run_session(prog, 0);
        if (last_writes.size() == 4) begin
            check_eq("lw_word", 64'(last_writes[0].data), 64'h8C010004);
            check_eq("sw_word", 64'(last_writes[1].data), 64'hAC430008);
            check_eq("beq_word", 64'(last_writes[2].data), 64'h1000FFFE);
            check_eq("j_word", 64'(last_writes[3].data), 64'h08000003);
            check_eq("j_addr", 64'(last_writes[3].addr), 64'd3);
        end else begin
            check_eq("b2b_nwrites", 64'(last_writes.size()), 64'd4);
        end

        // Illegal mnemonic after two legal words.
        prog = '{mk(0, 4, 5, 6, 0, 0, 1'b0), mk(3, 7, 8, 9, 0, 0, 1'b0),
                 mk(13, 1, 1, 1, 1, 1, 1'b0), mk(0, 1, 1, 1, 0, 0, 1'b1)};
        run_session(prog, 0);

        // Overflow: more words than capacity and no Last.
        prog.delete();
        for (int k = 0; k < CAP + 2; k++) prog.push_back(rand_instr(1'b0, 1'b0));
        run_session(prog, 0);

        // Reset during the WRITE cycle.
        mon_en = 1'b0;
        In_valid = 1'b0;
        Start    = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        send(mk(0, 1, 2, 3, 0, 0, 1'b0), acc);
        In_valid = 1'b0;
        check_eq("mid_we_before", 64'(Im_we), 64'd1);
        #2;
        Clrn = 1'b0;
        #1;
        check_eq("mid_we", 64'(Im_we), 64'd0);
        check_eq("mid_count", 64'(Count), 64'd0);
        check_eq("mid_hold", 64'(Cpu_hold), 64'd1);
        check_eq("mid_done", 64'(Done), 64'd0);
        #1;
        Clrn = 1'b1;
        @(posedge Clk);
        #1;
        check_eq("mid_idle_ready", 64'(In_ready), 64'd0);
        check_eq("mid_idle_addr", 64'(Im_addr), 64'(BASE));
        check_eq("mid_idle_hold", 64'(Cpu_hold), 64'd1);
        act_q.delete();
        mon_en = 1'b1;

        // Random programs, each started from DONE.
        for (int s = 0; s < 40; s++) begin
            prog.delete();
            with_last = ($urandom_range(0, 99) < 80);
            len = with_last ? $urandom_range(1, 6) : CAP + 2;
            for (int k = 0; k < len; k++) prog.push_back(rand_instr(with_last && k == len - 1, 1'b1));
            run_session(prog, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
